// File: rtl/map_sst_seq_pkg.sv
// map_sst_seq_pkg: shared save-state sequencer types and constants
package map_sst_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, FREEZE, S_ADDR, S_WR, CHECK, L_RD, L_LAT, L_WR, VERIFY, FIN
  } sst_state_t;
  localparam int SST_ID_ADDR = 127;
  localparam int WE_HOLD_DEF = 4;
endpackage

// File: rtl/map_sst_seq_if.sv
// map_sst_seq_if: command, freeze, SSTBus and buffer signals of the save-state sequencer
interface map_sst_seq_if;
  logic       cmd_save, cmd_load, busy, done, err, frz_req, frz_ack;
  logic       sst_act, sst_we_reg, buf_we;
  logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_dout, buf_din;
  modport master (
    input  cmd_save, cmd_load, frz_ack, sst_di, buf_din,
    output busy, done, err, frz_req, sst_act, sst_addr, sst_we_reg, sst_dato,
           buf_addr, buf_dout, buf_we
  );
  modport slave (
    output cmd_save, cmd_load, frz_ack, sst_di, buf_din,
    input  busy, done, err, frz_req, sst_act, sst_addr, sst_we_reg, sst_dato,
           buf_addr, buf_dout, buf_we
  );
endinterface

// File: rtl/map_sst_hold_ctr.sv
// map_sst_hold_ctr: down-counter that stretches each mapper write over HOLD clocks
module map_sst_hold_ctr
  import map_sst_seq_pkg::*;
#(
  parameter int HOLD = WE_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  localparam int W = $clog2(HOLD + 1);
  logic [W-1:0] cnt;
  // load HOLD-1 on entry so the write state lasts exactly HOLD cycles, then count to zero
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? W'(HOLD - 1) : cnt - W'(cnt != '0);
  assign expire = cnt == '0;
endmodule

// File: rtl/map_sst_seq.sv
// map_sst_seq: freezes the console and copies the mapper register window to/from a byte buffer (optional MAP_SST_VERIFY_EN adds a post-load verify pass)
module map_sst_seq
  import map_sst_seq_pkg::*;
#(
  parameter int REG_CNT = SST_ID_ADDR + 1,
  parameter int WE_HOLD = WE_HOLD_DEF
) (
  input logic clk,
  input logic rst,
  map_sst_seq_if.master sst
);
  localparam logic [7:0] LAST    = 8'(REG_CNT - 1);
  localparam logic [7:0] LD_LAST = 8'(REG_CNT - 2);
`ifdef MAP_SST_VERIFY_EN
  localparam sst_state_t LD_END = VERIFY;
`else
  localparam sst_state_t LD_END = FIN;
`endif
  sst_state_t st, nx;
  logic [7:0] i, dat;
  logic [1:0] ph;
  logic ld, err_q, we_exp, act, mis, cmd, clr, inc;
  assign cmd = sst.cmd_save | sst.cmd_load;
  assign mis = dat != sst.sst_di;
  assign clr = st == IDLE || st == CHECK || (st == L_WR && nx == VERIFY);
  assign inc = st == S_WR || (st == L_WR && we_exp) || (st == VERIFY && ph == 2'd2);
  map_sst_hold_ctr #(.HOLD(WE_HOLD)) u_hold (
    .clk(clk),
    .rst(rst),
    .load(st == L_LAT),
    .expire(we_exp)
  );
  // state register
  always_ff @(posedge clk)
    st <= rst ? IDLE : nx;
  // next state: walk the window, the ID byte is checked first and never written on load
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = cmd ? FREEZE : IDLE;
      FREEZE:  nx = !sst.frz_ack ? FREEZE : ld ? CHECK : S_ADDR;
      S_ADDR:  nx = S_WR;
      S_WR:    nx = i == LAST ? FIN : S_ADDR;
      CHECK:   nx = ph != 2'd2 ? CHECK : mis ? FIN : L_RD;
      L_RD:    nx = L_LAT;
      L_LAT:   nx = L_WR;
      L_WR:    nx = !we_exp ? L_WR : i != LD_LAST ? L_RD : LD_END;
      VERIFY:  nx = (ph == 2'd2 && i == LD_LAST) ? FIN : VERIFY;
      default: nx = IDLE;
    endcase
  end
  // index, compare phase, latched buffer byte, operation kind and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      i     <= '0;
      ph    <= '0;
      dat   <= '0;
      ld    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      i     <= clr ? 8'd0 : inc ? i + 8'd1 : i;
      ph    <= ((st == CHECK || st == VERIFY) && ph != 2'd2) ? ph + 2'd1 : 2'd0;
      dat   <= (st == L_LAT || ((st == CHECK || st == VERIFY) && ph == 2'd1)) ? sst.buf_din : dat;
      ld    <= (st == IDLE && cmd) ? !sst.cmd_save : ld;
      err_q <= (st == IDLE && cmd) ? 1'b0 :
               ((st == CHECK || st == VERIFY) && ph == 2'd2 && mis) ? 1'b1 : err_q;
    end
  end
  // outputs decoded from state; buffer and mapper share one address
  always_comb begin
    act            = !(st inside {IDLE, FREEZE, FIN});
    sst.busy       = !(st inside {IDLE, FIN});
    sst.frz_req    = !(st inside {IDLE, FIN});
    sst.done       = st == FIN;
    sst.err        = err_q;
    sst.sst_act    = act;
    sst.sst_addr   = act ? (st == CHECK ? LAST : i) : 8'd0;
    sst.buf_addr   = act ? (st == CHECK ? LAST : i) : 8'd0;
    sst.sst_we_reg = st == L_WR;
    sst.sst_dato   = st == L_WR ? dat : 8'd0;
    sst.buf_we     = st == S_WR;
    sst.buf_dout   = st == S_WR ? sst.sst_di : 8'd0;
  end
endmodule
